spi_reg_bridge: RTL and testbench
=================================

// Module: spi_reg_bridge
// PURPOSE
//   Parametrised successor to the fixed 16-bit SPI command decoder. It sits between the
//   SPI byte shifter and an internal register bus (CPU core, peripherals).
//   It decodes framed SPI transactions (cmd, addr, data words) into req/ack bus reads and
//   writes, with burst auto-increment, configurable word/address width and sticky error flags.
// PARAMETERS
//   DATA_W   16  bus word width in bits; multiple of 8, range 8..64; sent MSB byte first
//   ADDR_W    8  bus address width, 1..8; carried in one address byte (upper bits ignored)
// PORTS
//   clk           in   1       system clock
//   rst           in   1       asynchronous active-high reset
//   frame_active  in   1       high while SPI chip-select is asserted (already synchronised)
//   rx_valid      in   1       1-cycle pulse: rx_byte holds a complete received byte
//   rx_byte       in   8       received byte
//   tx_byte       out  8       byte the shifter loads at the next byte boundary
//   bus_req       out  1       bus request, held until acknowledged
//   bus_we        out  1       1 = write, 0 = read; stable while bus_req=1
//   bus_addr      out  ADDR_W  bus address; stable while bus_req=1
//   bus_wdata     out  DATA_W  write data; stable while bus_req=1
//   bus_rdata     in   DATA_W  read data, valid in the bus_ack cycle
//   bus_ack       in   1       completes the transaction when sampled with bus_req=1
//   busy          out  1       bus transaction outstanding
//   err_overrun   out  1       sticky: a write word was dropped (bus still busy)
//   err_underrun  out  1       sticky: read data was not ready when a tx byte was needed
// BEHAVIOUR
//   Reset: all outputs 0, FSM in IDLE, byte counter 0, rd_buf 0.
//   Cmd byte: [7] write, [6] incr, [5:0] reserved and must be 0.
//   Frame layout: cmd, addr, then data bytes. Guarantee: >=8 clk cycles between rx_valid pulses.
//   FSM states:
//     IDLE -> CMD on frame_active rise; both err flags cleared at that rise.
//     CMD: rx_valid with reserved bits != 0 -> DISCARD; otherwise latch we/incr -> ADDR.
//     ADDR: rx_valid latches addr -> WR (we=1), or -> RD (we=0) and issues a read at addr.
//     WR: assembles DATA_W/8 bytes MSB first. At the last byte of a word:
//       - bus idle: assert bus_req/we=1 with the word in the next cycle;
//       - bus busy: drop the word, set err_overrun.
//     RD: for each data byte k of the word, tx_byte = rd_buf[DATA_W-1-8k -: 8],
//       updated the cycle after the previous rx_valid (or after the ADDR rx_valid for k=0).
//       After the rx_valid of the last byte of a word, issue the next read.
//       If the read is not acked when tx_byte must update: tx_byte=0x00, err_underrun=1.
//       A late ack still loads rd_buf.
//     DISCARD: ignore all bytes; tx_byte=0x00; no bus activity.
//     Any state -> IDLE on frame_active fall. Partial words are discarded.
//   Addressing: incr=1 -> addr+1 after each issued word, modulo 2^ADDR_W (0xFF -> 0x00).
//     incr=0 -> same addr every word (FIFO-style register).
//   Bus handshake:
//     bus_req rises 1 cycle after the trigger and drops the cycle after ack sampled high.
//     Ack in the first req cycle is legal. Only one outstanding transaction.
//     A frame end never aborts an outstanding transaction; req holds until ack.
//     bus_wdata/bus_addr are held after completion, not cleared.
//   tx_byte = 0x00 in IDLE, CMD and ADDR.
//   rst mid-transaction: immediate return to reset values, bus_req drops asynchronously.
// TESTING (DATA_W=16, ADDR_W=8)
//   1. Assert rst mid-burst with bus_req=1 -> all outputs 0 at once; next frame decodes normally.
//   2. Write 0x80,0x12,0xAB,0xCD; ack 3 cycles after req -> exactly one req, we=1,
//      addr=0x12, wdata=0xABCD; req low the cycle after ack.
//   3. Write 0xC0,0xFF,0x11,0x22,0x33,0x44 -> writes 0x1122@0xFF then 0x3344@0x00 (wrap).
//   4. Read 0x00,0x05 with rdata=0xBEEF, 4 dummy bytes -> tx 0xBE,0xEF,0xBE,0xEF;
//      two reads, both addr 0x05.
//   5. Write burst, ack withheld 40 cycles, bytes every 10 cycles -> 2nd word dropped,
//      err_overrun=1; read with ack withheld -> tx 0x00, err_underrun=1;
//      both flags clear at next frame start.
//   6. Cmd 0x81 -> DISCARD, no bus_req; frame ending after 1 of 2 data bytes -> no bus_req.

Source files
------------

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: turns framed SPI byte traffic (cmd, addr, data words) into
// req/ack register-bus reads and writes. It supports burst auto-increment and
// sticky overrun/underrun flags. Words travel MSB byte first.
module spi_reg_bridge #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_active,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic [7:0]        tx_byte,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              busy,
  output logic              err_overrun,
  output logic              err_underrun
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WR,
    S_RD,
    S_DISCARD
  } state_t;

  state_t state, state_next;

  logic              cmd_we, cmd_incr;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  byte_cnt;
  logic [DATA_W-1:0] wr_shift;
  logic [DATA_W-1:0] rd_buf;
  logic              rd_ready;
  logic              rd_pend;
  logic              tx_upd;

  logic              rx_accept, frame_start, cmd_ok, word_done;
  logic              wr_issue, wr_drop, rd_trigger, rd_issue;
  logic              ack_now, rd_ack, rd_ack_rd, rd_have, underrun;
  logic [ADDR_W-1:0] rx_addr, issue_addr;
  logic [DATA_W-1:0] wr_word, rd_src;
  logic [7:0]        rd_byte;

  assign busy = bus_req;

  // State register: the frame decoder restarts from IDLE on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next state: a frame fall returns to IDLE from anywhere, else walk cmd/addr/data.
  always_comb begin
    state_next = state;
    if (state != S_IDLE && !frame_active) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (frame_active) state_next = S_CMD;
        S_CMD:   if (rx_valid) state_next = cmd_ok ? S_ADDR : S_DISCARD;
        S_ADDR:  if (rx_valid) state_next = cmd_we ? S_WR : S_RD;
        default: state_next = state;
      endcase
    end
  end

  // Decode: byte acceptance, word completion and bus issue/drop/underrun events.
  always_comb begin
    rx_accept   = rx_valid && frame_active;
    frame_start = (state == S_IDLE) && frame_active;
    cmd_ok      = (rx_byte[5:0] == 6'd0);
    rx_addr     = rx_byte[ADDR_W-1:0];
    word_done   = rx_accept && (byte_cnt == LAST_BYTE);
    wr_word     = DATA_W'({wr_shift, rx_byte});
    wr_issue    = (state == S_WR) && word_done && !bus_req;
    wr_drop     = (state == S_WR) && word_done && bus_req;
    rd_trigger  = rx_accept && (((state == S_ADDR) && !cmd_we) ||
                                ((state == S_RD) && (byte_cnt == LAST_BYTE)));
    rd_issue    = !bus_req && (rd_trigger ||
                               (rd_pend && (state == S_RD) && frame_active));
    issue_addr  = (state == S_ADDR) ? rx_addr : addr;
    ack_now     = bus_req && bus_ack;
    rd_ack      = ack_now && !bus_we;
    rd_ack_rd   = rd_ack && (state == S_RD) && !rd_pend;
    rd_have     = rd_ack_rd || rd_ready;
    rd_src      = rd_ack_rd ? bus_rdata : rd_buf;
    rd_byte     = 8'((rd_src << {byte_cnt, 3'b000}) >> (DATA_W - 8));
    underrun    = (state == S_RD) && tx_upd && frame_active && !rd_have;
  end

  // Command flags and the running word address, incremented per issued word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_we   <= 1'b0;
      cmd_incr <= 1'b0;
      addr     <= '0;
    end else begin
      if (state == S_CMD && rx_accept && cmd_ok) begin
        cmd_we   <= rx_byte[7];
        cmd_incr <= rx_byte[6];
      end
      if (state == S_ADDR && rx_accept) begin
        addr <= (rd_issue && cmd_incr) ? rx_addr + ADDR_W'(1) : rx_addr;
      end else if ((wr_issue || rd_issue) && cmd_incr) begin
        addr <= addr + ADDR_W'(1);
      end
    end
  end

  // Byte position within the current word and write-word assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      wr_shift <= '0;
    end else begin
      if (frame_start || (state == S_ADDR && rx_accept)) begin
        byte_cnt <= '0;
      end else if ((state == S_WR || state == S_RD) && rx_accept) begin
        byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + CNT_W'(1);
      end
      if (state == S_WR && rx_accept) wr_shift <= wr_word;
    end
  end

  // Bus master: one outstanding transaction, address/data held after completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rd_pend   <= 1'b0;
    end else begin
      if (ack_now) bus_req <= 1'b0;
      if (wr_issue) begin
        bus_req   <= 1'b1;
        bus_we    <= 1'b1;
        bus_addr  <= addr;
        bus_wdata <= wr_word;
      end else if (rd_issue) begin
        bus_req  <= 1'b1;
        bus_we   <= 1'b0;
        bus_addr <= issue_addr;
      end
      if (rd_issue)                rd_pend <= 1'b0;
      else if (rd_trigger)         rd_pend <= 1'b1;
      else if (state != S_RD)      rd_pend <= 1'b0;
    end
  end

  // Read side: capture read data and present the next byte after each rx byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_buf   <= '0;
      rd_ready <= 1'b0;
      tx_upd   <= 1'b0;
      tx_byte  <= 8'h00;
    end else begin
      if (rd_ack) rd_buf <= bus_rdata;
      if (frame_start || rd_trigger) rd_ready <= 1'b0;
      else if (rd_ack_rd)            rd_ready <= 1'b1;
      tx_upd <= rx_accept && (((state == S_ADDR) && !cmd_we) || (state == S_RD));
      if (state != S_RD)                tx_byte <= 8'h00;
      else if (tx_upd && frame_active)  tx_byte <= rd_have ? rd_byte : 8'h00;
    end
  end

  // Sticky error flags, cleared when a new frame begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_overrun  <= 1'b0;
      err_underrun <= 1'b0;
    end else if (frame_start) begin
      err_overrun  <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      if (wr_drop)  err_overrun  <= 1'b1;
      if (underrun) err_underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: directed test of the SPI-to-register-bus bridge with
// DATA_W=16, ADDR_W=8, a simple delayed-ack bus responder and a transaction log.
module tb_spi_reg_bridge;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_active;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic [7:0]        tx_byte;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;
  logic              busy;
  logic              err_overrun;
  logic              err_underrun;

  int n_checks = 0;
  int n_pass   = 0;

  int                ack_delay = 0;
  logic [DATA_W-1:0] rdata_val = '0;

  int                n_txn = 0;
  int                ack_drop_err = 0;
  logic              log_we    [0:31];
  logic [ADDR_W-1:0] log_addr  [0:31];
  logic [DATA_W-1:0] log_wdata [0:31];
  int                log_len   [0:31];

  assign bus_rdata = rdata_val;

  spi_reg_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_active (frame_active),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .tx_byte      (tx_byte),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack),
    .busy         (busy),
    .err_overrun  (err_overrun),
    .err_underrun (err_underrun)
  );

  always #5 clk = ~clk;

  // Bus responder: logs each new request and acks it after ack_delay req cycles.
  initial begin : responder
    int   age;
    logic prev_req;
    logic prev_ack;
    age = 0;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    bus_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_ack && bus_req) ack_drop_err++;
      bus_ack = 1'b0;
      if (bus_req) begin
        if (!prev_req) begin
          if (n_txn < 32) begin
            log_we[n_txn]    = bus_we;
            log_addr[n_txn]  = bus_addr;
            log_wdata[n_txn] = bus_wdata;
            log_len[n_txn]   = 0;
          end
          n_txn++;
          age = 0;
        end else begin
          age++;
        end
        if (n_txn > 0 && n_txn <= 32) log_len[n_txn-1]++;
        if (age >= ack_delay) bus_ack = 1'b1;
      end
      prev_req = bus_req;
      prev_ack = bus_ack;
    end
  end

  // Watchdog so the run always ends even if the sequence stalls.
  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: observed no completion, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else begin
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b, input int gap);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    tick(gap - 1);
  endtask

  task automatic frame_begin();
    frame_active = 1'b1;
    tick(2);
  endtask

  task automatic frame_end();
    frame_active = 1'b0;
    tick(3);
  endtask

  task automatic wait_idle(input string tag);
    int cycles;
    cycles = 0;
    while (bus_req === 1'b1 && cycles < 300) begin
      tick(1);
      cycles++;
    end
    check_output(tag, bus_req, 1'b0);
  endtask

  // Directed sequence covering reset, writes, reads, wrap, errors and discard.
  initial begin : main
    int base;
    rst = 1'b1;
    frame_active = 1'b0;
    rx_valid = 1'b0;
    rx_byte = 8'h00;
    tick(3);
    check_output("reset_bus_req", bus_req, 1'b0);
    check_output("reset_tx_byte", tx_byte, 8'h00);
    check_output("reset_bus_wdata", bus_wdata, 16'h0000);
    check_output("reset_flags", {busy, bus_we, err_overrun, err_underrun}, 4'b0000);
    rst = 1'b0;
    tick(2);

    // Reset in the middle of a burst with a request outstanding.
    $display("[TB] reset mid-burst");
    ack_delay = 1000;
    frame_begin();
    apply_stimulus(8'hC0, 10);
    apply_stimulus(8'h20, 10);
    apply_stimulus(8'h01, 10);
    apply_stimulus(8'h02, 3);
    check_output("t1_req_before_reset", bus_req, 1'b1);
    rst = 1'b1;
    #1;
    check_output("t1_req_async_drop", bus_req, 1'b0);
    check_output("t1_addr_cleared", bus_addr, 8'h00);
    check_output("t1_wdata_cleared", bus_wdata, 16'h0000);
    check_output("t1_flags_cleared", {busy, bus_we, err_overrun, err_underrun}, 4'b0000);
    @(negedge clk);
    frame_active = 1'b0;
    rst = 1'b0;
    ack_delay = 0;
    tick(3);

    // Single write, ack in the fourth request cycle.
    $display("[TB] single write");
    ack_delay = 3;
    base = n_txn;
    frame_begin();
    apply_stimulus(8'h80, 10);
    apply_stimulus(8'h12, 10);
    apply_stimulus(8'hAB, 10);
    apply_stimulus(8'hCD, 10);
    frame_end();
    check_output("t2_txn_count", n_txn - base, 1);
    check_output("t2_we", log_we[base], 1'b1);
    check_output("t2_addr", log_addr[base], 8'h12);
    check_output("t2_wdata", log_wdata[base], 16'hABCD);
    check_output("t2_req_len", log_len[base], 4);
    check_output("t2_req_after_ack", ack_drop_err, 0);
    check_output("t2_wdata_held", bus_wdata, 16'hABCD);
    ack_delay = 0;

    // Incrementing burst wrapping the address from 0xFF to 0x00.
    $display("[TB] incrementing write with wrap");
    base = n_txn;
    frame_begin();
    apply_stimulus(8'hC0, 10);
    apply_stimulus(8'hFF, 10);
    apply_stimulus(8'h11, 10);
    apply_stimulus(8'h22, 10);
    apply_stimulus(8'h33, 10);
    apply_stimulus(8'h44, 10);
    frame_end();
    check_output("t3_txn_count", n_txn - base, 2);
    check_output("t3_w0", {log_we[base], log_addr[base], log_wdata[base]}, {1'b1, 8'hFF, 16'h1122});
    check_output("t3_w1", {log_we[base+1], log_addr[base+1], log_wdata[base+1]}, {1'b1, 8'h00, 16'h3344});

    // Non-incrementing read of 0xBEEF, two words of dummy bytes.
    $display("[TB] fixed-address read");
    rdata_val = 16'hBEEF;
    base = n_txn;
    frame_begin();
    apply_stimulus(8'h00, 10);
    apply_stimulus(8'h05, 10);
    check_output("t4_tx0", tx_byte, 8'hBE);
    apply_stimulus(8'h00, 10);
    check_output("t4_tx1", tx_byte, 8'hEF);
    apply_stimulus(8'h00, 10);
    check_output("t4_tx2", tx_byte, 8'hBE);
    apply_stimulus(8'h00, 10);
    check_output("t4_tx3", tx_byte, 8'hEF);
    check_output("t4_txn_count", n_txn - base, 2);
    check_output("t4_r0", {log_we[base], log_addr[base]}, {1'b0, 8'h05});
    check_output("t4_r1", {log_we[base+1], log_addr[base+1]}, {1'b0, 8'h05});
    apply_stimulus(8'h00, 10);
    frame_end();
    wait_idle("t4_idle");

    // Overrun: second word arrives while the first is still waiting for ack.
    $display("[TB] overrun and underrun");
    ack_delay = 40;
    base = n_txn;
    frame_begin();
    apply_stimulus(8'h80, 10);
    apply_stimulus(8'h40, 10);
    apply_stimulus(8'hA1, 10);
    apply_stimulus(8'hA2, 10);
    apply_stimulus(8'hB1, 10);
    apply_stimulus(8'hB2, 10);
    check_output("t5_overrun_set", err_overrun, 1'b1);
    check_output("t5_busy_during", busy, 1'b1);
    frame_end();
    wait_idle("t5_write_idle");
    check_output("t5_one_write", n_txn - base, 1);
    check_output("t5_kept_word", log_wdata[base], 16'hA1A2);
    check_output("t5_overrun_sticky", err_overrun, 1'b1);

    // Underrun: read data not acked when the first tx byte is due.
    ack_delay = 30;
    frame_begin();
    check_output("t5_overrun_cleared", err_overrun, 1'b0);
    apply_stimulus(8'h00, 10);
    apply_stimulus(8'h05, 5);
    check_output("t5_underrun_tx", tx_byte, 8'h00);
    check_output("t5_underrun_set", err_underrun, 1'b1);
    frame_end();
    wait_idle("t5_read_idle");
    ack_delay = 0;

    // Reserved command bits send the frame to DISCARD.
    $display("[TB] discard and partial word");
    base = n_txn;
    frame_begin();
    check_output("t6_underrun_cleared", err_underrun, 1'b0);
    apply_stimulus(8'h81, 10);
    apply_stimulus(8'h10, 10);
    apply_stimulus(8'h55, 10);
    apply_stimulus(8'h66, 10);
    check_output("t6_discard_tx", tx_byte, 8'h00);
    check_output("t6_discard_no_req", n_txn - base, 0);
    frame_end();

    // A frame ending after half a word issues nothing.
    frame_begin();
    apply_stimulus(8'h80, 10);
    apply_stimulus(8'h10, 10);
    apply_stimulus(8'h55, 10);
    frame_end();
    tick(10);
    check_output("t6_partial_no_req", n_txn - base, 0);
    check_output("t6_req_low", bus_req, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
